parity_frame_rx: RTL and testbench

Serial frame receiver that checks the XOR parity produced by the team's parity generator path. It deserialises one frame of start bit, DATA_W data bits (LSB first), parity bit and stop bit, and sits at the receiving end of the serial link. It presents the parallel word with a one-cycle valid strobe plus parity and framing error flags. Bit timing comes from an external strobe, so the block contains no oversampling or baud logic.

---
 rtl/parity_frame_rx.sv | 133 +++++++++++++
 tb/tb_parity_frame_rx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit, timed by bit_en.
// Define PARITY_FRAME_RX_STICKY_ERR_EN to add err_clr / err_sticky error latching.
module parity_frame_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
`ifdef PARITY_FRAME_RX_STICKY_ERR_EN
  input  logic              err_clr,
  output logic              err_sticky,
`endif
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic        LP_ODD = (ODD_PARITY != 0);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;
  logic                r_par_bad;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_data_valid;
  logic                r_parity_err;
  logic                r_frame_err;
  logic                r_busy;
  logic [DATA_W-1:0]   w_shift_nxt;

  // LSB-first shift: each new bit enters at the MSB end
  always_comb begin
    w_shift_nxt = r_shift >> 1;
    w_shift_nxt[DATA_W-1] = serial_in;
  end

  // Frame FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_par_bad    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (bit_en) begin
        case (r_state)
          S_IDLE: begin
            if (!serial_in) begin
              r_state <= S_DATA;
              r_cnt   <= '0;
              r_par   <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift <= w_shift_nxt;
            r_par   <= r_par ^ serial_in;
            r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_cnt == CNT_W'(DATA_W - 1)) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_par_bad <= (serial_in != (r_par ^ LP_ODD));
            r_state   <= S_STOP;
          end
          S_STOP: begin
            r_data_out   <= r_shift;
            r_parity_err <= r_par_bad;
            r_frame_err  <= ~serial_in;
            r_data_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

`ifdef PARITY_FRAME_RX_STICKY_ERR_EN
  logic w_err_done;
  logic r_err_sticky;

  // A completion with either error flag set, seen on the stop-bit sample
  always_comb begin
    w_err_done = 1'b0;
    if (bit_en && (r_state == S_STOP)) begin
      w_err_done = r_par_bad | ~serial_in;
    end else begin
      w_err_done = 1'b0;
    end
  end

  // Sticky error: setting has priority over clearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
    end else if (w_err_done) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench for parity_frame_rx: stimulus pushes expected frames, a negedge monitor pops and compares.
module tb_parity_frame_rx;
  localparam int DW  = 8;
  localparam int ODD = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bit_en = 1'b0;
  logic          serial_in = 1'b1;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;
`ifdef PARITY_FRAME_RX_STICKY_ERR_EN
  logic          err_clr = 1'b0;
  logic          err_sticky;
`endif

  int total = 0;
  int bad   = 0;
  logic [DW+1:0] exp_q[$];

  parity_frame_rx #(.DATA_W(DW), .ODD_PARITY(ODD)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .serial_in(serial_in),
    .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err),
`ifdef PARITY_FRAME_RX_STICKY_ERR_EN
    .err_clr(err_clr), .err_sticky(err_sticky),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap idle cycles (bit_en=0, random line noise) then one sampled bit
  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bit_en = 1'b0;
      serial_in = 1'($urandom);
      tick();
    end
    bit_en = 1'b1;
    serial_in = b;
    tick();
    bit_en = 1'b0;
    serial_in = 1'b1;
  endtask

  // Reference model: expected parity bit is XOR of data bits, inverted for odd parity
  task automatic send_frame(input logic [DW-1:0] d, input logic par_bit,
                            input logic stop_bit, input int gap);
    logic good_par;
    good_par = (^d) ^ (ODD != 0);
    exp_q.push_back({d, par_bit != good_par, !stop_bit});
    send_bit(1'b0, gap);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < DW; i++) send_bit(d[i], gap);
    send_bit(par_bit, gap);
    send_bit(stop_bit, gap);
    check("busy_after_stop", busy, 0);
  endtask

  // Monitor: every valid strobe must match the oldest expected frame
  always @(negedge clk) begin
    if (!rst && data_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: data_out=%0h no frame expected", data_out);
      end else begin
        logic [DW+1:0] e;
        e = exp_q.pop_front();
        if ({data_out, parity_err, frame_err} != e) begin
          bad++;
          $display("FAIL frame: got data=%0h perr=%0b ferr=%0b expected data=%0h perr=%0b ferr=%0b",
                   data_out, parity_err, frame_err, e[DW+1:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic flip, stp;
    int gap;
    repeat (3) tick();
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check("a5_valid_pulse", data_valid, 1);
    tick();
    check("a5_valid_one_cycle", data_valid, 0);
    send_frame(8'h01, 1'b0, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 3);
    repeat (2) tick();

    // Reset mid-frame after 4 data bits: no pulse, all outputs clear at once
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_perr", parity_err, 0);
    check("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    send_frame(8'h5A, 1'b0, 1'b1, 0);

    // Idle line: no frame may start
    bit_en = 1'b1;
    serial_in = 1'b1;
    repeat (50) tick();
    check("idle_busy", busy, 0);
    bit_en = 1'b0;

    for (int n = 0; n < 30; n++) begin
      d    = DW'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stp  = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 3);
      send_frame(d, ((^d) ^ (ODD != 0)) ^ flip, stp, gap);
    end

`ifdef PARITY_FRAME_RX_STICKY_ERR_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("sticky_cleared", err_sticky, 0);
    send_frame(8'h01, 1'b0, 1'b1, 0);
    check("sticky_set", err_sticky, 1);
    send_frame(8'h03, 1'b0, 1'b1, 0);
    check("sticky_hold_clean", err_sticky, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("sticky_clr", err_sticky, 0);
    err_clr = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1, 0);
    err_clr = 1'b0;
    check("sticky_set_wins", err_sticky, 1);
`endif

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
